// File: rtl/operand_fetch_stage.sv
// rtl/operand_fetch_stage.sv - elastic register-access stage between decode and execute
//
// Purpose: holds the integer register file and resolves operands A/B through a
// priority forwarding network. Load-use hazards stall the stage through the
// in_valid/in_ready and out_valid/out_ready handshakes. JALR targets are
// resolved early and a flush path kills the entries held here.
//
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   in_valid/in_ready               decode-side handshake
//   rs1, rs2, need_rs1, need_rs2    source indices and "architecturally read" flags
//   use_pc_a, use_imm_b, pc, imm    operand selects, pc and immediate
//   rd_in, is_jalr, ctrl_in         destination, JALR flag, opaque control bundle
//   flush                           kill every entry held in the stage
//   wb_en, wb_rd, wb_data           register-file write port
//   fwd_valid/pending/rd/data       packed forwarding sources, index 0 youngest
//   out_valid/out_ready             execute-side handshake
//   data_a, data_b, rs2_value       resolved operands
//   pc_out, imm_out, rd_out, ctrl_out  passed-through fields
//   jalr_redirect, jalr_target, ret_hint  early JALR redirect
module operand_fetch_stage #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int FWD_SRCS = 3,
  parameter int CTRL_W   = 16,
  localparam int RW      = $clog2(NREG)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [RW-1:0]            rs1,
  input  logic [RW-1:0]            rs2,
  input  logic                     need_rs1,
  input  logic                     need_rs2,
  input  logic                     use_pc_a,
  input  logic                     use_imm_b,
  input  logic [XLEN-1:0]          pc,
  input  logic [XLEN-1:0]          imm,
  input  logic [RW-1:0]            rd_in,
  input  logic                     is_jalr,
  input  logic [CTRL_W-1:0]        ctrl_in,
  input  logic                     flush,
  input  logic                     wb_en,
  input  logic [RW-1:0]            wb_rd,
  input  logic [XLEN-1:0]          wb_data,
  input  logic [FWD_SRCS-1:0]      fwd_valid,
  input  logic [FWD_SRCS-1:0]      fwd_pending,
  input  logic [FWD_SRCS*RW-1:0]   fwd_rd,
  input  logic [FWD_SRCS*XLEN-1:0] fwd_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          data_a,
  output logic [XLEN-1:0]          data_b,
  output logic [XLEN-1:0]          rs2_value,
  output logic [XLEN-1:0]          pc_out,
  output logic [XLEN-1:0]          imm_out,
  output logic [RW-1:0]            rd_out,
  output logic [CTRL_W-1:0]        ctrl_out,
  output logic                     jalr_redirect,
  output logic [XLEN-1:0]          jalr_target,
  output logic                     ret_hint
);

  logic [XLEN-1:0] rf [NREG];

  // H slot
  logic              h_valid;
  logic [RW-1:0]     h_rs1, h_rs2, h_rd;
  logic              h_need1, h_need2, h_use_pc_a, h_use_imm_b, h_jalr;
  logic [XLEN-1:0]   h_pc, h_imm;
  logic [CTRL_W-1:0] h_ctrl;

  logic [XLEN-1:0] res_a, res_b, jalr_sum;
  logic            pend_a, pend_b, hazard, advance;

  // Returns {pending, value}. The loop runs oldest-to-youngest so the lowest
  // matching index is the last assignment and therefore wins.
  function automatic logic [XLEN:0] resolve(input logic [RW-1:0] s);
    logic [XLEN:0] r;
    r = {1'b0, rf[s]};
    if (wb_en && wb_rd == s) r = {1'b0, wb_data};
    for (int i = FWD_SRCS - 1; i >= 0; i--) begin
      if (fwd_valid[i] && fwd_rd[i*RW +: RW] == s)
        r = {fwd_pending[i], fwd_data[i*XLEN +: XLEN]};
    end
    if (s == '0) r = '0;
    return r;
  endfunction

  always_comb begin
    {pend_a, res_a} = resolve(h_rs1);
    {pend_b, res_b} = resolve(h_rs2);
    hazard   = h_valid && ((h_need1 && pend_a) || (h_need2 && pend_b));
    advance  = h_valid && !hazard && (!out_valid || out_ready);
    jalr_sum = res_a + h_imm;
  end

  // Acceptance may coincide with H advancing into O.
  assign in_ready = !flush && (!h_valid || advance);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (wb_en && wb_rd != '0) begin
      rf[wb_rd] <= wb_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_valid     <= 1'b0;
      h_rs1       <= '0;
      h_rs2       <= '0;
      h_rd        <= '0;
      h_need1     <= 1'b0;
      h_need2     <= 1'b0;
      h_use_pc_a  <= 1'b0;
      h_use_imm_b <= 1'b0;
      h_jalr      <= 1'b0;
      h_pc        <= '0;
      h_imm       <= '0;
      h_ctrl      <= '0;
    end else if (flush) begin
      h_valid <= 1'b0;
    end else if (in_valid && in_ready) begin
      h_valid     <= 1'b1;
      h_rs1       <= rs1;
      h_rs2       <= rs2;
      h_rd        <= rd_in;
      h_need1     <= need_rs1;
      h_need2     <= need_rs2;
      h_use_pc_a  <= use_pc_a;
      h_use_imm_b <= use_imm_b;
      h_jalr      <= is_jalr;
      h_pc        <= pc;
      h_imm       <= imm;
      h_ctrl      <= ctrl_in;
    end else if (advance) begin
      h_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid     <= 1'b0;
      data_a        <= '0;
      data_b        <= '0;
      rs2_value     <= '0;
      pc_out        <= '0;
      imm_out       <= '0;
      rd_out        <= '0;
      ctrl_out      <= '0;
      jalr_redirect <= 1'b0;
      jalr_target   <= '0;
      ret_hint      <= 1'b0;
    end else begin
      // Redirect is a single-cycle pulse; ret_hint only means something with it.
      jalr_redirect <= 1'b0;
      ret_hint      <= 1'b0;
      if (flush) begin
        out_valid <= 1'b0;
      end else if (advance) begin
        out_valid <= 1'b1;
        data_a    <= h_use_pc_a ? h_pc : res_a;
        data_b    <= h_use_imm_b ? h_imm : res_b;
        rs2_value <= res_b;
        pc_out    <= h_pc;
        imm_out   <= h_imm;
        rd_out    <= h_rd;
        ctrl_out  <= h_ctrl;
        if (h_jalr) begin
          jalr_redirect <= 1'b1;
          jalr_target   <= {jalr_sum[XLEN-1:1], 1'b0};
          ret_hint      <= (h_rd == '0) && (h_rs1 == RW'(1) || h_rs1 == RW'(5));
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/operand_fetch_stage.md
Name: operand_fetch_stage

Overview:
Parametrised register-access stage between decode and execute in the RISC-V pipeline. It holds the integer register file and resolves operands A/B through an N-source priority forwarding network. It detects load-use hazards and stalls through valid/ready handshakes. It resolves JALR targets early, with a return hint and a flush path. It replaces the fixed-width, always-advancing register-access stage with an elastic, configurable one.

Parameters:
XLEN, 32, datapath width.
NREG, 32, architectural register count; register index width RW = clog2(NREG).
FWD_SRCS, 3, number of forwarding sources; index 0 has highest priority (youngest).
CTRL_W, 16, width of the opaque decode control bundle passed through unchanged.

Ports:
clk  in  1  clock.
reset  in  1  asynchronous, active-high.
in_valid  in  1  decode entry offered.
in_ready  out  1  stage can accept the entry this cycle.
rs1, rs2  in  RW each  source register indices.
need_rs1, need_rs2  in  1 each  the source is architecturally read (used for hazard check).
use_pc_a, use_imm_b  in  1 each  operand A = pc; operand B = imm.
pc, imm  in  XLEN each  instruction pc and immediate.
rd_in  in  RW  destination register.
is_jalr  in  1  the entry is a JALR.
ctrl_in  in  CTRL_W  pass-through control bundle.
flush  in  1  kill all entries held in this stage.
wb_en, wb_rd, wb_data  in  1/RW/XLEN  register-file write port.
fwd_valid, fwd_pending  in  FWD_SRCS each  source has a destination / result not yet available.
fwd_rd  in  FWD_SRCS*RW  packed destination indices.
fwd_data  in  FWD_SRCS*XLEN  packed results.
out_valid  out  1  the output entry is valid.
out_ready  in  1  execute accepts the entry.
data_a, data_b, rs2_value  out  XLEN each  resolved operands; rs2_value is always the resolved rs2.
pc_out, imm_out  out  XLEN each.
rd_out  out  RW.
ctrl_out  out  CTRL_W.
jalr_redirect  out  1  one-cycle pulse.
jalr_target  out  XLEN  redirect target.
ret_hint  out  1  qualifies jalr_redirect.

Behaviour:
- Reset (async): all valid flags 0; every output 0; all register-file entries 0.
- Register file: write on posedge when wb_en and wb_rd!=0. Reads are combinational. Index 0 always reads 0.
- Two internal slots:
  - H (hold): captures the inputs on in_valid && in_ready.
  - O (output): drives the out_* ports.
- Latency with no stall is 2 cycles from acceptance to out_valid.
- Operand resolution for each source s of H, first match wins:
  - lowest index i with fwd_valid[i] && fwd_rd[i]==s && s!=0: use fwd_data[i];
  - else wb_en && wb_rd==s && s!=0: use wb_data;
  - else register-file value.
- hazard = H valid and, for some needed source s!=0, the winning forward match has fwd_pending set.
- advance = H valid && !hazard && (!O valid || out_ready).
- On advance, O captures:
  - data_a = use_pc_a ? pc : resolved rs1;
  - data_b = use_imm_b ? imm : resolved rs2;
  - the remaining fields unchanged.
- in_ready = !flush && (!H valid || advance). A new entry can be accepted in the same cycle H advances.
- O is released on out_valid && out_ready with no new advance; out_valid then drops to 0. While out_valid && !out_ready, all O outputs hold stable.
- JALR: on an advance with is_jalr, the next cycle has:
  - jalr_redirect = 1 for exactly one cycle;
  - jalr_target = (resolved rs1 + imm) mod 2^XLEN with bit 0 cleared;
  - ret_hint = (rd_in==0 && rs1 in {1,5}).
- A stalled JALR asserts nothing until it advances.
- flush (synchronous):
  - clears H valid and O valid at the next edge;
  - suppresses acceptance and any redirect issued that edge;
  - has priority over advance and out_ready.
- Reset mid-stall or mid-flush returns the stage to the reset state immediately.

Test Plan:
1. Reset, then write x5=0x10 via WB. Offer rs1=5, rs2=0, use_imm_b=1, imm=4 -> after 2 cycles: out_valid=1, data_a=0x10, data_b=4, rs2_value=0.
2. fwd0 and fwd1 both rd=5, data 0xAA/0xBB, WB also writing x5=0xCC -> data_a=0xAA. Drop fwd0 -> 0xBB. Drop fwd1 -> 0xCC.
3. fwd0 valid+pending, rd=7; entry reads rs2=7 with need_rs2=1 -> in_ready=0, no advance for 3 cycles. Clear pending with fwd_data=0x55 -> advance; rs2_value=0x55 one cycle later.
4. Hold out_ready=0 for 4 cycles with two entries queued -> O outputs unchanged and in_ready=0 once H is full. Release -> entries emerge in order, none lost.
5. JALR with rs1=1 holding 0x1003, imm=0, rd=0 -> one-cycle jalr_redirect, jalr_target=0x1002, ret_hint=1. Same with rd=1 -> ret_hint=0.
6. Assert flush while both slots are valid and a JALR is advancing -> next cycle out_valid=0 and jalr_redirect=0. Writes to x0 read back 0 throughout.
